// File: rtl/tones_pkg.sv
// Shared constants for the tones block: key count, note code width, the
// half-period table (2 us ticks, C4..D#5) and the priority key-to-note lookup.
package tones_pkg;

  localparam int NUM_KEYS = 16;
  localparam int TONE_W   = 10;

  // Entry i is the half-period of semitone i above C4; index 0 is rightmost.
  localparam logic [NUM_KEYS-1:0][TONE_W-1:0] NOTE_TABLE = {
    10'd402, 10'd426, 10'd451, 10'd478, 10'd506, 10'd536, 10'd568, 10'd602,
    10'd638, 10'd676, 10'd716, 10'd758, 10'd804, 10'd851, 10'd902, 10'd956
  };

  // Lowest-index pressed key wins; no key pressed gives 0.
  function automatic logic [TONE_W-1:0] key_to_n(input logic [NUM_KEYS-1:0] keys);
    logic [TONE_W-1:0] n;
    n = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (keys[i[3:0]]) n = NOTE_TABLE[i[3:0]];
    end
    return n;
  endfunction

endpackage

// File: rtl/tones_pwm.sv
// Free-running 8-bit PWM counter with amplitude compare, gated by en.
// Only built when TONES_VOLUME_EN is defined.
module tones_pwm (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] volume,
  input  logic       en,
  output logic       pwm
);

  logic [7:0] pwm_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pwm_cnt <= '0;
    else     pwm_cnt <= pwm_cnt + 8'd1;
  end

  assign pwm = en && (pwm_cnt < volume);

endmodule

// File: rtl/tones.sv
// Sixteen-key single-voice square-wave tone generator for a mono PWM amplifier.
// Optional build macro TONES_VOLUME_EN: PWM-scale AIN by volume (default: AIN = square).
module tones
  import tones_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  volume,
  input  logic [15:0] keys,
  output logic        AIN,
  output logic        GAIN,
  output logic        SHUTDOWN_L,
  output logic [9:0]  N
);

  localparam int TICK_DIV = CLK_FREQ_HZ / 500_000;
  localparam int TICK_W   = $clog2(TICK_DIV + 1);

  logic [TICK_W-1:0] tick_cnt;
  logic              tick;
  logic [TONE_W-1:0] n_next;
  logic [TONE_W-1:0] phase;
  logic              square;
  logic              ain_next;

  assign n_next = key_to_n(keys);
  assign tick   = (tick_cnt == TICK_W'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt   <= '0;
      phase      <= '0;
      square     <= 1'b0;
      N          <= '0;
      SHUTDOWN_L <= 1'b0;
      GAIN       <= 1'b0;
      AIN        <= 1'b0;
    end else begin
      GAIN       <= 1'b1;
      N          <= n_next;
      SHUTDOWN_L <= (n_next != '0);
      AIN        <= ain_next;
      tick_cnt   <= tick ? '0 : tick_cnt + 1'b1;
      // A new note restarts the waveform low; silence holds it low.
      if ((N != n_next) || (N == '0)) begin
        phase  <= '0;
        square <= 1'b0;
      end else if (tick) begin
        if (phase == N - 1'b1) begin
          phase  <= '0;
          square <= ~square;
        end else begin
          phase  <= phase + 1'b1;
        end
      end
    end
  end

`ifdef TONES_VOLUME_EN
  tones_pwm u_pwm (
    .clk    (clk),
    .rst    (rst),
    .volume (volume),
    .en     (square),
    .pwm    (ain_next)
  );
`else
  logic unused_volume;
  assign unused_volume = ^volume;
  assign ain_next      = square;
`endif

endmodule

// File: tb/tb_tones.sv
// Directed bench for tones; runs with a 2.5 MHz clock parameter so one tick is
// 5 clk cycles and square half-periods stay short (N * 5 cycles).
module tb_tones;

  localparam int TDIV = 5;

  logic        clk;
  logic        rst;
  logic [7:0]  volume;
  logic [15:0] keys;
  logic        ain;
  logic        gain;
  logic        shutdown_l;
  logic [9:0]  n;

  int vectors;
  int miscompares;

  logic [9:0] exp_table [16] = '{
    10'd956, 10'd902, 10'd851, 10'd804, 10'd758, 10'd716, 10'd676, 10'd638,
    10'd602, 10'd568, 10'd536, 10'd506, 10'd478, 10'd451, 10'd426, 10'd402
  };

  tones #(.CLK_FREQ_HZ(2_500_000)) dut (
    .clk        (clk),
    .rst        (rst),
    .volume     (volume),
    .keys       (keys),
    .AIN        (ain),
    .GAIN       (gain),
    .SHUTDOWN_L (shutdown_l),
    .N          (n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; keys = '0; volume = 8'd200;
    repeat (3) @(negedge clk);
    vectors++;
    if (n !== 10'd0 || ain !== 1'b0 || gain !== 1'b0 || shutdown_l !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_values: N=%0d AIN=%b GAIN=%b SD_L=%b, want 0 0 0 0", n, ain, gain, shutdown_l);
    end
    rst = 1'b0;
  endtask

  task automatic test_idle();
    int bad_n, bad_sd, bad_ain, bad_gain;
    bad_n = 0; bad_sd = 0; bad_ain = 0; bad_gain = 0;
    keys = '0;
    repeat (2000) begin
      @(negedge clk);
      if (n !== 10'd0) bad_n++;
      if (shutdown_l !== 1'b0) bad_sd++;
      if (ain !== 1'b0) bad_ain++;
      if (gain !== 1'b1) bad_gain++;
    end
    vectors++;
    if (bad_n != 0) begin miscompares++; $display("FAIL idle_n: %0d cycles with N!=0, want 0", bad_n); end
    vectors++;
    if (bad_sd != 0) begin miscompares++; $display("FAIL idle_shutdown: %0d cycles with SD_L=1, want 0", bad_sd); end
    vectors++;
    if (bad_ain != 0) begin miscompares++; $display("FAIL idle_ain: %0d cycles with AIN=1, want 0", bad_ain); end
    vectors++;
    if (bad_gain != 0) begin miscompares++; $display("FAIL idle_gain: %0d cycles with GAIN=0, want 1", bad_gain); end
  endtask

  task automatic test_walking_one();
    for (int i = 0; i < 16; i++) begin
      keys = 16'h0001 << i;
      @(negedge clk);
      vectors++;
      if (n !== exp_table[i] || shutdown_l !== 1'b1) begin
        miscompares++;
        $display("FAIL walk_key%0d: N=%0d SD_L=%b, want N=%0d SD_L=1", i, n, shutdown_l, exp_table[i]);
      end
      repeat (3000) @(negedge clk);
    end
    keys = '0;
    @(negedge clk);
    vectors++;
    if (n !== 10'd0 || shutdown_l !== 1'b0) begin
      miscompares++;
      $display("FAIL walk_off: N=%0d SD_L=%b, want N=0 SD_L=0", n, shutdown_l);
    end
    @(negedge clk);
    vectors++;
    if (ain !== 1'b0) begin
      miscompares++;
      $display("FAIL walk_off_ain: AIN=%b, want 0", ain);
    end
  endtask

  task automatic test_priority();
    logic [15:0] pk [3] = '{16'h0210, 16'h8000, 16'hFFFF};
    logic [9:0]  pn [3] = '{10'd758, 10'd402, 10'd956};
    for (int i = 0; i < 3; i++) begin
      keys = pk[i];
      @(negedge clk);
      vectors++;
      if (n !== pn[i]) begin
        miscompares++;
        $display("FAIL priority_%h: N=%0d, want %0d", pk[i], n, pn[i]);
      end
    end
    keys = '0;
    repeat (2) @(negedge clk);
  endtask

`ifndef TONES_VOLUME_EN
  task automatic test_square_period();
    int cnt;
    volume = 8'd0;
    keys = 16'h0001;
    cnt = 0;
    while (ain !== 1'b1 && cnt < 20000) begin @(negedge clk); cnt++; end
    vectors++;
    if (ain !== 1'b1) begin
      miscompares++;
      $display("FAIL square_start: AIN never rose in %0d cycles", cnt);
    end else begin
      cnt = 0;
      do begin @(negedge clk); cnt++; end while (ain === 1'b1 && cnt < 20000);
      vectors++;
      if (cnt != 956 * TDIV) begin
        miscompares++;
        $display("FAIL square_high: %0d cycles, want %0d", cnt, 956 * TDIV);
      end
      cnt = 0;
      do begin @(negedge clk); cnt++; end while (ain === 1'b0 && cnt < 20000);
      vectors++;
      if (cnt != 956 * TDIV) begin
        miscompares++;
        $display("FAIL square_low: %0d cycles, want %0d", cnt, 956 * TDIV);
      end
    end
    keys = '0;
    repeat (2) @(negedge clk);
  endtask
`else
  task automatic test_volume();
    int cnt, highs;
    volume = 8'd0;
    keys = 16'h0200;
    highs = 0;
    repeat (6000) begin @(negedge clk); if (ain === 1'b1) highs++; end
    vectors++;
    if (highs != 0) begin
      miscompares++;
      $display("FAIL volume0: AIN high %0d cycles, want 0", highs);
    end
    volume = 8'd128;
    keys = '0;
    @(negedge clk);
    keys = 16'h0200;
    cnt = 0;
    while (ain !== 1'b1 && cnt < 8000) begin @(negedge clk); cnt++; end
    vectors++;
    if (ain !== 1'b1) begin
      miscompares++;
      $display("FAIL volume128_start: AIN never rose in %0d cycles", cnt);
    end else begin
      highs = 0;
      for (int i = 0; i < 256; i++) begin
        if (ain === 1'b1) highs++;
        @(negedge clk);
      end
      vectors++;
      if (highs != 128) begin
        miscompares++;
        $display("FAIL volume128_duty: AIN high %0d of 256, want 128", highs);
      end
    end
    volume = 8'd255;
    keys = '0;
    repeat (2) @(negedge clk);
  endtask
`endif

  task automatic test_reset_mid_tone();
    int cnt;
    keys = 16'h0001;
    cnt = 0;
    while (ain !== 1'b1 && cnt < 20000) begin @(negedge clk); cnt++; end
    vectors++;
    if (ain !== 1'b1 || n !== 10'd956) begin
      miscompares++;
      $display("FAIL midreset_tone: AIN=%b N=%0d, want AIN=1 N=956", ain, n);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (n !== 10'd0 || ain !== 1'b0 || shutdown_l !== 1'b0 || gain !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_async: N=%0d AIN=%b SD_L=%b GAIN=%b, want all 0", n, ain, shutdown_l, gain);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++;
    if (n !== 10'd0) begin
      miscompares++;
      $display("FAIL midreset_release: N=%0d, want 0", n);
    end
    @(negedge clk);
    vectors++;
    if (n !== 10'd956 || shutdown_l !== 1'b1 || gain !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_reload: N=%0d SD_L=%b GAIN=%b, want 956 1 1", n, shutdown_l, gain);
    end
    keys = '0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_idle();
    test_walking_one();
    test_priority();
`ifndef TONES_VOLUME_EN
    test_square_period();
`else
    test_volume();
`endif
    test_reset_mid_tone();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
